boreal_sigverify: RTL and testbench

BOREAL_SIGVERIFY -- requirements
Module: boreal_sigverify

---
 rtl/boreal_sigverify.sv | 171 +++++++++++++++++
 tb/tb_boreal_sigverify.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/boreal_sigverify.sv
// Constant-time digest verifier: compares a request hash against bus-programmed slots.
// Optional lockout after repeated failures is enabled by defining BOREAL_SIGVERIFY_LOCKOUT_EN.
module boreal_sigverify #(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned SLOT_LOG       = 2,
  parameter int unsigned COMPARE_CYCLES = 8,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_start,
  input  logic [31:0] sig_hash_in,
  output logic        sig_pass,
  output logic        sig_ready,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        lockout
);

  localparam int unsigned CNT_W  = $clog2(COMPARE_CYCLES + 1);
  localparam int unsigned FAIL_W = 8;
`ifdef BOREAL_SIGVERIFY_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_PAD, S_RESULT} state_t;

  state_t              r_state, w_state_next;
  logic                w_accept, w_count, w_cmp, w_result;

  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_hash;
  logic                r_match;
  logic                r_pass;
  logic                r_ready;
  logic                r_lockout;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic                r_cfg_lock;
  logic [NUM_SLOTS-1:0] r_valid;
  logic [31:0]         r_slot [NUM_SLOTS];
  logic                r_ack;
  logic [31:0]         r_rdata;

  logic [5:0]          w_word;
  logic                w_wr, w_cfg_wr, w_hit, w_busy;
  logic [SLOT_LOG-1:0] w_idx;
  logic [FAIL_W-1:0]   w_fail_next;
  logic [31:0]         w_rd;
  logic                w_unused_addr;

  assign w_word        = addr[7:2];
  assign w_unused_addr = ^{addr[31:8], addr[1:0]};
  assign w_wr          = sel & we;
  assign w_busy        = (r_state != S_IDLE);
  // Configuration is frozen while a verify runs or once cfg_lock is set.
  assign w_cfg_wr      = w_wr & ~r_cfg_lock & ~w_busy;
  assign w_idx         = r_cnt[SLOT_LOG-1:0];
  assign w_hit         = r_valid[w_idx] & (r_slot[w_idx] == r_hash);
  assign w_fail_next   = (r_fail_cnt == {FAIL_W{1'b1}}) ? r_fail_cnt : r_fail_cnt + FAIL_W'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and control strobes; timing never depends on the data.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_count      = 1'b0;
    w_cmp        = 1'b0;
    w_result     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sig_start) begin
          w_accept     = 1'b1;
          w_state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_count = 1'b1;
        w_cmp   = 1'b1;
        if (r_cnt == CNT_W'(NUM_SLOTS - 1)) w_state_next = S_PAD;
      end
      S_PAD: begin
        w_count = 1'b1;
        if (r_cnt == CNT_W'(COMPARE_CYCLES - 1)) w_state_next = S_RESULT;
      end
      S_RESULT: begin
        w_result     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Register read mux.
  always_comb begin
    w_rd = '0;
    if (w_word < 6'(NUM_SLOTS)) begin
      w_rd = r_slot[w_word[SLOT_LOG-1:0]];
    end else begin
      case (w_word)
        6'd16:   w_rd = 32'(r_valid);
        6'd17:   w_rd = {31'b0, r_cfg_lock};
        6'd18:   w_rd = {21'b0, w_busy, r_pass, r_lockout, r_fail_cnt};
        default: w_rd = '0;
      endcase
    end
  end

  // Datapath, bus and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_hash     <= '0;
      r_match    <= 1'b0;
      r_pass     <= 1'b0;
      r_ready    <= 1'b1;
      r_lockout  <= 1'b0;
      r_fail_cnt <= '0;
      r_cfg_lock <= 1'b0;
      r_valid    <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
    end else begin
      r_ready <= (w_state_next == S_IDLE);
      r_ack   <= sel;
      r_rdata <= sel ? w_rd : '0;

      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (w_cfg_wr && (w_word == 6'(i))) r_slot[i] <= wdata;
      end
      if (w_cfg_wr && (w_word == 6'd16)) r_valid <= wdata[NUM_SLOTS-1:0];
      if (w_wr && (w_word == 6'd17) && wdata[0]) r_cfg_lock <= 1'b1;

      if (w_accept) begin
        r_hash  <= sig_hash_in;
        r_pass  <= 1'b0;
        r_match <= 1'b0;
        r_cnt   <= '0;
      end else if (w_count) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_cmp) r_match <= r_match | w_hit;
      end

      if (w_result) begin
        r_pass <= r_match & ~r_lockout;
        if (!r_match) begin
          r_fail_cnt <= w_fail_next;
          if (LOCK_EN && (w_fail_next >= FAIL_W'(MAX_FAIL))) r_lockout <= 1'b1;
        end
      end
    end
  end

  assign sig_pass  = r_pass;
  assign sig_ready = r_ready;
  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign lockout   = r_lockout;

endmodule

// File: tb/tb_boreal_sigverify.sv
// Directed self-checking bench for boreal_sigverify (default build or BOREAL_SIGVERIFY_LOCKOUT_EN).
module tb_boreal_sigverify;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_start;
  logic [31:0] sig_hash_in;
  logic        sig_pass;
  logic        sig_ready;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        lockout;

  int checks = 0;
  int errors = 0;

`ifdef BOREAL_SIGVERIFY_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  boreal_sigverify dut (
    .clk(clk), .rst(rst), .sig_start(sig_start), .sig_hash_in(sig_hash_in),
    .sig_pass(sig_pass), .sig_ready(sig_ready), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    check("wr_ack", 32'(ack), 32'd1);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    tick();
    check("rd_ack", 32'(ack), 32'd1);
    d = rdata;
    sel = 1'b0;
  endtask

  // Runs one request; optional extra sig_start at busy cycle inj_at, optional write in the start cycle.
  task automatic verify(input logic [31:0] h, input int inj_at, input logic [31:0] inj_h,
                        input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                        output int busy);
    sig_start = 1'b1; sig_hash_in = h;
    if (wr) begin sel = 1'b1; we = 1'b1; addr = wa; wdata = wd; end
    tick();
    sig_start = 1'b0; sel = 1'b0; we = 1'b0;
    busy = 0;
    while (!sig_ready && busy < 50) begin
      busy++;
      if (busy == 1) check("pass_cleared", 32'(sig_pass), 32'd0);
      if (busy == inj_at) begin sig_start = 1'b1; sig_hash_in = inj_h; end
      tick();
      sig_start = 1'b0;
    end
  endtask

  logic [31:0] rd;
  int          busy;

  initial begin
    rst = 1'b1; sig_start = 1'b0; sig_hash_in = '0;
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    check("rst_ready",   32'(sig_ready), 32'd1);
    check("rst_pass",    32'(sig_pass),  32'd0);
    check("rst_ack",     32'(ack),       32'd0);
    check("rst_rdata",   rdata,          32'd0);
    check("rst_lockout", 32'(lockout),   32'd0);
    rst = 1'b0;
    tick();

    // Basic pass on slot0.
    bus_write(32'h00, 32'hDEADBEEF);
    bus_write(32'h40, 32'h1);
    bus_read(32'h00, rd); check("slot0_rd", rd, 32'hDEADBEEF);
    verify(32'hDEADBEEF, 0, 0, 1'b0, 0, 0, busy);
    check("pass_busy", 32'(busy), 32'd9);
    check("pass_res",  32'(sig_pass), 32'd1);
    bus_read(32'h48, rd); check("pass_status", rd, 32'h200);

    // Empty valid mask always fails, same busy time.
    bus_write(32'h40, 32'h0);
    verify(32'hDEADBEEF, 0, 0, 1'b0, 0, 0, busy);
    check("nomask_busy", 32'(busy), 32'd9);
    check("nomask_res",  32'(sig_pass), 32'd0);
    bus_read(32'h48, rd); check("nomask_status", rd, 32'h001);

    // Mismatching hash, then match in the last slot.
    bus_write(32'h40, 32'h1);
    verify(32'h12345678, 0, 0, 1'b0, 0, 0, busy);
    check("miss_res", 32'(sig_pass), 32'd0);
    bus_write(32'h0C, 32'hCAFEF00D);
    bus_write(32'h40, 32'h8);
    verify(32'hCAFEF00D, 0, 0, 1'b0, 0, 0, busy);
    check("slot3_busy", 32'(busy), 32'd9);
    check("slot3_res",  32'(sig_pass), 32'd1);
    bus_read(32'h48, rd); check("slot3_status", rd, 32'h202);

    // sig_start during COMPARE is ignored.
    bus_write(32'h40, 32'h9);
    verify(32'hDEADBEEF, 2, 32'h11111111, 1'b0, 0, 0, busy);
    check("ignore_busy", 32'(busy), 32'd9);
    check("ignore_res",  32'(sig_pass), 32'd1);
    bus_read(32'h48, rd); check("ignore_status", rd, 32'h202);

    // Write in the start cycle commits before the compare.
    verify(32'h55AA55AA, 0, 0, 1'b1, 32'h00, 32'h55AA55AA, busy);
    check("samecyc_res", 32'(sig_pass), 32'd1);
    bus_read(32'h00, rd); check("samecyc_slot0", rd, 32'h55AA55AA);

    // Reset in PAD aborts, clears state; fresh verify passes.
    sig_start = 1'b1; sig_hash_in = 32'h55AA55AA;
    tick();
    sig_start = 1'b0;
    repeat (5) tick();
    check("pad_busy", 32'(sig_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(sig_ready), 32'd1);
    check("abort_pass",  32'(sig_pass),  32'd0);
    bus_read(32'h48, rd); check("abort_status", rd, 32'h000);
    bus_read(32'h00, rd); check("abort_slot0", rd, 32'h0);
    bus_write(32'h00, 32'h55AA55AA);
    bus_write(32'h40, 32'h1);
    verify(32'h55AA55AA, 0, 0, 1'b0, 0, 0, busy);
    check("postrst_res", 32'(sig_pass), 32'd1);

    // Three failures, then a matching hash.
    for (int k = 0; k < 3; k++) begin
      verify(32'h00000000, 0, 0, 1'b0, 0, 0, busy);
      check("fail_res", 32'(sig_pass), 32'd0);
    end
    check("lock_after3", 32'(lockout), 32'(LOCK_EN));
    verify(32'h55AA55AA, 0, 0, 1'b0, 0, 0, busy);
    check("lock_busy", 32'(busy), 32'd9);
    check("lock_res",  32'(sig_pass), LOCK_EN ? 32'd0 : 32'd1);
    bus_read(32'h48, rd); check("lock_status", rd, LOCK_EN ? 32'h103 : 32'h203);

    // cfg_lock freezes slots and mask.
    bus_write(32'h44, 32'h1);
    bus_read(32'h44, rd); check("cfglock_rd", rd, 32'h1);
    bus_write(32'h04, 32'h12345678);
    bus_read(32'h04, rd); check("locked_slot1", rd, 32'h0);
    bus_write(32'h40, 32'h0);
    bus_read(32'h40, rd); check("locked_mask", rd, 32'h1);
    bus_read(32'h80, rd); check("unmapped_rd", rd, 32'h0);
    tick();
    check("idle_ack",   32'(ack), 32'd0);
    check("idle_rdata", rdata,    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
